// File: rtl/inst_mem_arbiter.sv
// inst_mem_arbiter: shares one asynchronous 32-bit SRAM between instruction
// fetch and MEM-stage data accesses. Fetch owns the bus whenever no data
// access is in flight. A load takes one SRAM cycle. A store takes setup and
// strobe cycles. Every access ends with a one-cycle ACK state.
// Build option: define SRAM_WR_HOLD_EN to add a write-hold cycle after the
// strobe (3-cycle store instead of 2-cycle).
module inst_mem_arbiter #(
    parameter int SRAM_AW = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        if_pc,
    input  logic               mem_req,
    input  logic               mem_we,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_wdata,
    input  logic [3:0]         mem_be,
    output logic [31:0]        if_inst,
    output logic [31:0]        mem_rdata,
    output logic               mem_ack,
    output logic               is_load_store,
    output logic               stallreq,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  logic [31:0]        sram_data,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic [3:0]         sram_be_n
);

    typedef enum logic [2:0] {
        FETCH,
        LOAD,
        ST_SETUP,
        ST_STROBE,
`ifdef SRAM_WR_HOLD_EN
        ST_HOLD,
`endif
        ACK
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        mem_ack_q, mem_ack_d;
    logic        wr_drive;
    logic        new_req;

    // A request is only accepted while no ack is being presented, so a request
    // held high through the ack cycle cannot trigger a second access early.
    assign new_req = mem_req & ~mem_ack_q;

    // The arbiter drives the data bus only while a store is in progress.
    assign sram_data = wr_drive ? mem_wdata : 'z;

    assign mem_rdata = mem_rdata_q;
    assign mem_ack   = mem_ack_q;

    // Next-state and SRAM/pipeline outputs. Reset overrides the outputs
    // combinationally, so a store aborted by reset never sees a low we_n.
    always_comb begin
        state_d       = state_q;
        sram_addr     = if_pc[SRAM_AW+1:2];
        sram_ce_n     = 1'b0;
        sram_oe_n     = 1'b0;
        sram_we_n     = 1'b1;
        sram_be_n     = '0;
        wr_drive      = 1'b0;
        if_inst       = '0;
        stallreq      = new_req;
        is_load_store = (state_q != FETCH) | new_req;

        case (state_q)
            FETCH: begin
                if_inst = sram_data;
                if (new_req) begin
                    state_d = mem_we ? ST_SETUP : LOAD;
                end
            end
            LOAD: begin
                sram_addr = mem_addr[SRAM_AW+1:2];
                state_d   = ACK;
            end
            ST_SETUP: begin
                sram_addr = mem_addr[SRAM_AW+1:2];
                sram_oe_n = 1'b1;
                sram_be_n = ~mem_be;
                wr_drive  = 1'b1;
                state_d   = ST_STROBE;
            end
            ST_STROBE: begin
                sram_addr = mem_addr[SRAM_AW+1:2];
                sram_oe_n = 1'b1;
                sram_we_n = 1'b0;
                sram_be_n = ~mem_be;
                wr_drive  = 1'b1;
`ifdef SRAM_WR_HOLD_EN
                state_d   = ST_HOLD;
`else
                state_d   = ACK;
`endif
            end
`ifdef SRAM_WR_HOLD_EN
            ST_HOLD: begin
                sram_addr = mem_addr[SRAM_AW+1:2];
                sram_oe_n = 1'b1;
                sram_be_n = ~mem_be;
                wr_drive  = 1'b1;
                state_d   = ACK;
            end
`endif
            ACK: begin
                state_d = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if (rst) begin
            sram_ce_n     = 1'b1;
            sram_oe_n     = 1'b1;
            sram_we_n     = 1'b1;
            sram_be_n     = '1;
            wr_drive      = 1'b0;
            if_inst       = '0;
            stallreq      = 1'b0;
            is_load_store = 1'b0;
        end
    end

    // Load data is captured at the end of the LOAD cycle. The ack flop
    // mirrors entry into ACK, so the pulse lasts exactly one cycle.
    always_comb begin
        mem_rdata_d = mem_rdata_q;
        if (state_q == LOAD) begin
            mem_rdata_d = sram_data;
        end
        mem_ack_d = (state_d == ACK);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            mem_rdata_q <= '0;
            mem_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_rdata_q <= mem_rdata_d;
            mem_ack_q   <= mem_ack_d;
        end
    end

endmodule
